// File: rtl/plab3_mem_line_word_adapter.sv
// rtl/plab3_mem_line_word_adapter.sv - cacheline-to-word memory request adapter
//
// Purpose:
//   Sits between a blocking cache's line-wide memory port and a word-wide
//   memory. One line request (READ refill or WRITE evict) is split into
//   nbeats = clw/dbw word requests. The in-order word responses are gathered,
//   and one line response goes back to the cache. Word requests are
//   pipelined, so up to nbeats words can be outstanding at once.
//
// Optional feature (macro PLAB3_MEM_LINE_WORD_ADAPTER_CHECK_EN):
//   When the macro is defined, each accepted word response's opaque field is
//   compared with the expected beat index. A mismatch sets the sticky err
//   flag. The macro also adds an assertion on the accepted request type.
//   When the macro is undefined, err is tied to 0.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   linereq_*             line request from the cache (val/rdy, type, opaque,
//                         addr, data)
//   lineresp_*            line response to the cache (val/rdy, type, opaque,
//                         data)
//   wordreq_*             word request to memory (val/rdy, type, opaque = beat
//                         index, addr, data)
//   wordresp_*            word response from memory (val/rdy, opaque, data)
//   err                   sticky protocol error flag

module plab3_mem_line_word_adapter #(
  parameter int p_opaque_nbits = 8,
  parameter int abw            = 32,
  parameter int dbw            = 32,
  parameter int clw            = 128
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      linereq_val,
  output logic                      linereq_rdy,
  input  logic [2:0]                linereq_type,
  input  logic [p_opaque_nbits-1:0] linereq_opaque,
  input  logic [abw-1:0]            linereq_addr,
  input  logic [clw-1:0]            linereq_data,

  output logic                      lineresp_val,
  input  logic                      lineresp_rdy,
  output logic [2:0]                lineresp_type,
  output logic [p_opaque_nbits-1:0] lineresp_opaque,
  output logic [clw-1:0]            lineresp_data,

  output logic                      wordreq_val,
  input  logic                      wordreq_rdy,
  output logic [2:0]                wordreq_type,
  output logic [p_opaque_nbits-1:0] wordreq_opaque,
  output logic [abw-1:0]            wordreq_addr,
  output logic [dbw-1:0]            wordreq_data,

  input  logic                      wordresp_val,
  output logic                      wordresp_rdy,
  input  logic [p_opaque_nbits-1:0] wordresp_opaque,
  input  logic [dbw-1:0]            wordresp_data,

  output logic                      err
);

  localparam int nbeats  = clw / dbw;
  localparam int c_idx_w = $clog2(nbeats);
  localparam int c_cnt_w = c_idx_w + 1;

  localparam logic [c_cnt_w-1:0] c_nbeats      = c_cnt_w'(nbeats);
  localparam logic [c_cnt_w-1:0] c_last_beat   = c_cnt_w'(nbeats - 1);
  localparam logic [abw-1:0]     c_line_mask   = ~abw'(clw / 8 - 1);
  localparam logic [2:0]         c_type_read   = 3'd0;
  localparam logic [2:0]         c_type_write  = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;

  logic [2:0]                  r_type;
  logic [p_opaque_nbits-1:0]   r_opaque;
  logic [abw-1:0]              r_addr;
  logic [clw-1:0]              r_line;
  logic [c_cnt_w-1:0]          r_req_cnt;
  logic [c_cnt_w-1:0]          r_resp_cnt;

  logic                        w_accept;
  logic                        w_req_fire;
  logic                        w_resp_fire;
  logic [c_idx_w-1:0]          w_req_idx;
  logic [c_idx_w-1:0]          w_resp_idx;

  // Slot indices; the counter MSB only matters for the "all beats done"
  // comparisons, never for selecting a word.
  assign w_req_idx  = r_req_cnt[c_idx_w-1:0];
  assign w_resp_idx = r_resp_cnt[c_idx_w-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    linereq_rdy  = 1'b0;
    lineresp_val = 1'b0;
    wordreq_val  = 1'b0;
    wordresp_rdy = 1'b0;
    w_accept     = 1'b0;
    w_req_fire   = 1'b0;
    w_resp_fire  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        linereq_rdy  = 1'b1;
        // Responses are always drained while idle, so any leftovers from a
        // transaction abandoned by reset are absorbed and dropped.
        wordresp_rdy = 1'b1;
        if (linereq_val) begin
          w_accept     = 1'b1;
          w_state_next = ST_BUSY;
        end
      end

      ST_BUSY: begin
        wordreq_val  = (r_req_cnt < c_nbeats);
        // Accept only responses for beats that have been issued. This
        // prevents an early or stray response from being counted.
        wordresp_rdy = (r_resp_cnt < r_req_cnt);
        w_req_fire   = wordreq_val && wordreq_rdy;
        w_resp_fire  = wordresp_val && wordresp_rdy;
        if (w_resp_fire && (r_resp_cnt == c_last_beat)) begin
          w_state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        lineresp_val = 1'b1;
        if (lineresp_rdy) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_type     <= 3'd0;
      r_opaque   <= '0;
      r_addr     <= '0;
      r_line     <= '0;
      r_req_cnt  <= '0;
      r_resp_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_type     <= linereq_type;
        r_opaque   <= linereq_opaque;
        r_addr     <= linereq_addr & c_line_mask;
        r_req_cnt  <= '0;
        r_resp_cnt <= '0;
        if (linereq_type == c_type_write) begin
          r_line <= linereq_data;
        end
      end

      if (w_req_fire) begin
        r_req_cnt <= r_req_cnt + c_cnt_w'(1);
      end

      if (w_resp_fire) begin
        r_resp_cnt <= r_resp_cnt + c_cnt_w'(1);
        if (r_type == c_type_read) begin
          r_line[dbw*w_resp_idx +: dbw] <= wordresp_data;
        end
      end
    end
  end

  assign wordreq_type    = r_type;
  assign wordreq_opaque  = p_opaque_nbits'(r_req_cnt);
  // The line is aligned, so adding the beat offset cannot carry out of the
  // line.
  assign wordreq_addr    = r_addr + (abw'(r_req_cnt) << 2);
  assign wordreq_data    = (r_type == c_type_write) ? r_line[dbw*w_req_idx +: dbw] : '0;

  assign lineresp_type   = r_type;
  assign lineresp_opaque = r_opaque;
  assign lineresp_data   = (r_type == c_type_write) ? '0 : r_line;

`ifdef PLAB3_MEM_LINE_WORD_ADAPTER_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_resp_fire && (wordresp_opaque != p_opaque_nbits'(r_resp_cnt))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  always_ff @(posedge clk) begin
    if (reset && w_accept) begin
      assert ((linereq_type == c_type_read) || (linereq_type == c_type_write));
    end
  end
`else
  logic w_unused_opaque;

  assign w_unused_opaque = ^wordresp_opaque;
  assign err             = 1'b0;
`endif

endmodule

// File: doc/plab3_mem_line_word_adapter.md
Name: plab3_mem_line_word_adapter

Overview:
Sits directly downstream of the blocking cache controller's memory port. It accepts one cacheline-wide refill (READ) or evict (WRITE) request and splits it into clw/dbw word-wide requests to a word-wide test/main memory. It collects the in-order word responses and returns a single cacheline-wide response to the cache. Word requests may be pipelined; up to nbeats words can be outstanding.

Parameters:
p_opaque_nbits, 8, opaque field width on both sides
abw, 32, address width
dbw, 32, memory-side data width
clw, 128, cacheline width; clw/dbw must be a power of two ≥ 2
nbeats, clw/dbw, words per line (local, not set externally)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
linereq_val  in  1  cache memreq valid
linereq_rdy  out  1  cache memreq ready
linereq_type  in  3  READ (refill) or WRITE (evict); other types are illegal
linereq_opaque  in  p_opaque_nbits  echoed in the line response
linereq_addr  in  abw  line address; low log2(clw/8) bits ignored
linereq_data  in  clw  evict data
lineresp_val  out  1  line response valid
lineresp_rdy  in  1  line response ready
lineresp_type  out  3  equals the latched request type
lineresp_opaque  out  p_opaque_nbits  equals the latched request opaque
lineresp_data  out  clw  assembled refill data; 0 for WRITE
wordreq_val  out  1  memory request valid
wordreq_rdy  in  1  memory request ready
wordreq_type  out  3  latched request type
wordreq_opaque  out  p_opaque_nbits  beat index, zero-extended
wordreq_addr  out  abw  line base + 4*beat
wordreq_data  out  dbw  word `beat` of the latched line (bits [dbw*beat +: dbw]); 0 for READ
wordresp_val  in  1  memory response valid
wordresp_rdy  out  1  memory response ready
wordresp_opaque  in  p_opaque_nbits  beat index returned by memory
wordresp_data  in  dbw  read word
err  out  1  sticky protocol error flag (see Optional Feature)

Behaviour:
- States: IDLE, BUSY, RESP.
- While reset is low, asynchronously: state=IDLE, req_cnt=0, resp_cnt=0, line buffer=0, err=0.
- Outputs at reset: linereq_rdy=1, lineresp_val=0, wordreq_val=0, wordresp_rdy=1.
- IDLE:
  - linereq_rdy=1.
  - On linereq_val&&linereq_rdy: latch type, opaque, addr with low bits zeroed, and data (data only for WRITE). Clear both counters and go to BUSY.
  - wordresp_rdy=1 in IDLE. Any response accepted there is discarded, so stray responses from before a reset are absorbed.
- BUSY:
  - wordreq_val=(req_cnt<nbeats). A beat fires on wordreq_val&&wordreq_rdy, and req_cnt then increments.
  - wordresp_rdy=(resp_cnt<req_cnt). On a word response fire, a READ writes wordresp_data into buffer slot resp_cnt; resp_cnt then increments.
  - A request fire and a response fire in the same cycle are both honoured.
  - When resp_cnt reaches nbeats on the last response fire, go to RESP the next cycle.
  - Fastest transaction: 1 accept cycle + nbeats + 1 cycles with a zero-latency combinational memory.
- RESP:
  - lineresp_val=1; other handshakes deasserted (linereq_rdy=0, wordreq_val=0, wordresp_rdy=0).
  - On lineresp_val&&lineresp_rdy, go to IDLE. A new linereq is not accepted in that same cycle; the first accept is in IDLE.
- Counters are log2(nbeats)+1 bits wide and do not wrap within a transaction. Addresses add without carry checks, since the line is aligned.
- Memory responses are assumed in order. lineresp outputs are stable while lineresp_val=1 and lineresp_rdy=0.
- A reset assertion mid-transaction abandons it: no lineresp is produced and the buffer is lost.

Optional Feature:
PLAB3_MEM_LINE_WORD_ADAPTER_CHECK_EN:
- Defined: every BUSY response fire compares wordresp_opaque with resp_cnt. On mismatch, err is set and stays set until reset; the data is still stored. The block also VC_ASSERTs that linereq_type is READ or WRITE when a request is accepted.
- Not defined: err is tied 0, and no comparator or assertion is built.

Test Plan:
1. READ, addr 0x0000_1004, memory holds 0x11,0x22,0x33,0x44 at 0x1000–0x100C, zero latency → word addrs 0x1000/04/08/0C with opaque 0..3; lineresp_data=0x00000044_00000033_00000022_00000011, opaque echoed, arrives 6 cycles after accept.
2. WRITE, addr 0x2000, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → word writes AAAA… to 0x2000 through DDDD… to 0x200C; lineresp_type=WRITE, data=0.
3. Random wordreq_rdy and wordresp_val stalls plus lineresp_rdy held low 5 cycles → correct data, no duplicate or skipped beats, lineresp stable while stalled.
4. Reset pulsed low after 2 beats issued, then one stale response arrives in IDLE → response absorbed, next READ returns correct line.
5. With CHECK_EN defined, memory returns opaque 2 for beat 1 → err=1 and stays 1 until reset. Without the macro, err stays 0.
6. Back-to-back READ then WRITE with linereq_val held high → second request is accepted only in IDLE after the first lineresp fires.
